// File: rtl/shift_register_seq.sv
// Sequencer for a CIC interpolator/decimator delay-line shift register.
// It accepts samples over valid/ready and pulses the shift-register enable once
// per accepted sample. It tracks the commutator phase modulo gp_decim and
// flags when the line is primed. After the line is full it raises a held
// output-valid once every gp_decim samples; downstream can stall that output.
module shift_register_seq #(
  parameter int gp_nr_stages = 4,
  parameter int gp_decim     = 4,
  localparam int c_ph_width  = $clog2(gp_decim),
  localparam int c_cnt_width = $clog2(gp_nr_stages + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ena,
  input  logic                  i_clear,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_sr_ena,
  output logic [c_ph_width-1:0] o_phase,
  output logic                  o_fill_done,
  output logic                  o_out_valid,
  input  logic                  i_out_ready
);

  localparam logic [c_cnt_width-1:0] c_cnt_full = c_cnt_width'(gp_nr_stages);
  localparam logic [c_cnt_width-1:0] c_cnt_last = c_cnt_width'(gp_nr_stages - 1);
  localparam logic [c_ph_width-1:0]  c_ph_last  = c_ph_width'(gp_decim - 1);
  localparam logic [c_ph_width-1:0]  c_ph_one   = c_ph_width'(1);
  localparam logic [c_cnt_width-1:0] c_cnt_one  = c_cnt_width'(1);

  // Architectural state: fill count, commutator phase, primed flag, pending output.
  logic [c_cnt_width-1:0] cnt_q, cnt_d;
  logic [c_ph_width-1:0]  phase_q, phase_d;
  logic                   fill_q, fill_d;
  logic                   out_valid_q, out_valid_d;

  logic accept;
  logic out_event;

  // Handshake: no sample is taken while frozen, in reset or flush, or while an output waits.
  always_comb begin
    o_ready  = i_ena & ~i_rst & ~i_clear & ~out_valid_q;
    accept   = i_valid & o_ready;
    o_sr_ena = accept;
    // The line is primed either already, or by this very accept (the last missing sample).
    out_event = accept && (phase_q == c_ph_last) && (fill_q || (cnt_q == c_cnt_last));
  end

  // Next-state: clear beats freeze, freeze beats normal operation.
  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path leaves
    // it unassigned and no latch is inferred.
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    if (i_clear) begin
      cnt_d       = '0;
      phase_d     = '0;
      fill_d      = 1'b0;
      out_valid_d = 1'b0;
    end else if (i_ena) begin
      if (out_valid_q && i_out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        if (cnt_q != c_cnt_full) begin
          cnt_d = cnt_q + c_cnt_one;
        end
        phase_d = (phase_q == c_ph_last) ? '0 : phase_q + c_ph_one;
        if (cnt_q == c_cnt_last) begin
          fill_d = 1'b1;
        end
        if (out_event) begin
          out_valid_d = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    if (i_rst) begin
      cnt_q       <= '0;
      phase_q     <= '0;
      fill_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o_phase     = phase_q;
  assign o_fill_done = fill_q;
  assign o_out_valid = out_valid_q;

endmodule

// File: tb/tb_shift_register_seq.sv
// Directed bench for shift_register_seq. Unit A (N=4, R=4) runs a sequence of
// directed steps. Each step pushes the expected cycle outputs to a scoreboard
// queue and pops them at the falling edge. Unit B (N=6, R=4) streams samples
// continuously; the accept index expected at each output comes from a second queue.
module tb_shift_register_seq;

  typedef struct packed {
    logic       rdy;
    logic       sr;
    logic [1:0] ph;
    logic       fill;
    logic       ov;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Unit A stimulus and outputs.
  logic       rst, clr, ena, vld, ordy;
  logic       a_rdy, a_sr, a_fill, a_ov;
  logic [1:0] a_ph;

  // Unit B stimulus and outputs.
  logic       b_rst, b_clr, b_ena, b_vld, b_ordy;
  logic       b_rdy, b_sr, b_fill, b_ov;
  logic [1:0] b_ph;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   b_acc = 0;
  int   b_outs = 0;
  logic b_fill_prev = 1'b0;
  exp_t exp_q[$];
  int   b_exp_q[$];

  shift_register_seq #(.gp_nr_stages(4), .gp_decim(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_clear(clr), .i_valid(vld),
    .o_ready(a_rdy), .o_sr_ena(a_sr), .o_phase(a_ph), .o_fill_done(a_fill),
    .o_out_valid(a_ov), .i_out_ready(ordy)
  );

  shift_register_seq #(.gp_nr_stages(6), .gp_decim(4)) u_b (
    .i_clk(clk), .i_rst(b_rst), .i_ena(b_ena), .i_clear(b_clr), .i_valid(b_vld),
    .o_ready(b_rdy), .o_sr_ena(b_sr), .o_phase(b_ph), .o_fill_done(b_fill),
    .o_out_valid(b_ov), .i_out_ready(b_ordy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Unit B: an output must appear exactly at the queued accept count, and the
  // fill flag must rise after the sixth accept.
  task automatic check_b();
    int want;
    if (b_ov) begin
      b_outs++;
      want = (b_exp_q.size() > 0) ? b_exp_q.pop_front() : -1;
      chk("b_out_at_accept", b_acc, want);
      chk("b_ready_in_hold", int'(b_rdy), 0);
    end
    if (b_fill && !b_fill_prev) chk("b_fill_at_accept", b_acc, 6);
    b_fill_prev = b_fill;
    if (b_sr) b_acc++;
  endtask

  // One clock cycle: drive unit A inputs, queue its expected outputs, compare at negedge.
  task automatic step(input logic s_rst, s_clr, s_ena, s_vld, s_ordy,
                      input logic e_rdy, e_sr, input logic [1:0] e_ph,
                      input logic e_fill, e_ov);
    exp_t e, got;
    rst = s_rst; clr = s_clr; ena = s_ena; vld = s_vld; ordy = s_ordy;
    e = '{rdy: e_rdy, sr: e_sr, ph: e_ph, fill: e_fill, ov: e_ov};
    exp_q.push_back(e);
    @(negedge clk);
    got = exp_q.pop_front();
    chk("ready",     int'(a_rdy),  int'(got.rdy));
    chk("sr_ena",    int'(a_sr),   int'(got.sr));
    chk("phase",     int'(a_ph),   int'(got.ph));
    chk("fill_done", int'(a_fill), int'(got.fill));
    chk("out_valid", int'(a_ov),   int'(got.ov));
    check_b();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; ena = 1'b1; vld = 1'b0; ordy = 1'b0;
    b_rst = 1'b1; b_clr = 1'b0; b_ena = 1'b1; b_vld = 1'b0; b_ordy = 1'b1;
    b_exp_q = '{8, 12, 16, 20, 24};
    @(posedge clk);
    #1;
    // Reset still high: registers hold their reset values and ready is forced low.
    rst = 1'b1;
    @(negedge clk);
    chk("ready_in_reset",  int'(a_rdy),  0);
    chk("sr_ena_in_reset", int'(a_sr),   0);
    chk("phase_reset",     int'(a_ph),   0);
    chk("fill_reset",      int'(a_fill), 0);
    chk("ov_reset",        int'(a_ov),   0);
    @(posedge clk);
    #1;
    b_rst = 1'b0; b_vld = 1'b1;

    //   rst clr ena vld ordy | rdy sr ph fill ov
    // Continuous input, downstream always ready: four accepts, bubble, four accepts.
    step(0, 0, 1, 1, 1,  1, 1, 2'd0, 0, 0);  // c0
    step(0, 0, 1, 1, 1,  1, 1, 2'd1, 0, 0);  // c1
    step(0, 0, 1, 1, 1,  1, 1, 2'd2, 0, 0);  // c2
    step(0, 0, 1, 1, 1,  1, 1, 2'd3, 0, 0);  // c3 output event
    step(0, 0, 1, 1, 1,  0, 0, 2'd0, 1, 1);  // c4 HOLD bubble
    step(0, 0, 1, 1, 1,  1, 1, 2'd0, 1, 0);  // c5
    step(0, 0, 1, 1, 1,  1, 1, 2'd1, 1, 0);  // c6
    step(0, 0, 1, 1, 1,  1, 1, 2'd2, 1, 0);  // c7
    step(0, 0, 1, 1, 0,  1, 1, 2'd3, 1, 0);  // c8 output event
    // Back-pressure: five stalled HOLD cycles, then release.
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 1, 0,  0, 0, 2'd0, 1, 1); // c9..c13
    step(0, 0, 1, 1, 1,  0, 0, 2'd0, 1, 1);  // c14 consumed at this edge
    step(0, 0, 1, 1, 1,  1, 1, 2'd0, 1, 0);  // c15 accept resumes
    step(0, 0, 1, 1, 1,  1, 1, 2'd1, 1, 0);  // c16 phase becomes 2
    // Clear with valid high: no accept, then fill and phase restart.
    step(0, 1, 1, 1, 1,  0, 0, 2'd2, 1, 0);  // c17
    step(0, 0, 1, 1, 1,  1, 1, 2'd0, 0, 0);  // c18
    step(0, 0, 1, 1, 1,  1, 1, 2'd1, 0, 0);  // c19 count reaches 2
    // Freeze during fill for three cycles.
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 1, 1,  0, 0, 2'd2, 0, 0); // c20..c22
    step(0, 0, 1, 1, 1,  1, 1, 2'd2, 0, 0);  // c23
    step(0, 0, 1, 1, 0,  1, 1, 2'd3, 0, 0);  // c24 fourth fresh accept, output event
    // Freeze during HOLD: out_ready is ignored.
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 1, 1,  0, 0, 2'd0, 1, 1); // c25..c27
    step(0, 0, 1, 1, 0,  0, 0, 2'd0, 1, 1);  // c28 still holding
    // Reset in HOLD.
    step(1, 0, 1, 1, 0,  0, 0, 2'd0, 1, 1);  // c29
    step(0, 0, 1, 0, 0,  1, 0, 2'd0, 0, 0);  // c30 no valid, no accept
    step(0, 0, 1, 0, 0,  1, 0, 2'd0, 0, 0);  // c31

    chk("b_outputs_seen", b_outs, 5);
    chk("a_scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus sequence stalls.
  initial begin
    #100000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_register_seq.md
# shift_register_seq

Sequencer for the CIC-interpolator/decimator delay-line shift register. It accepts input samples over a valid/ready handshake and drives the shift register's enable, one pulse per accepted sample. It also tracks the commutator phase modulo the decimation ratio and reports when the line is primed. It issues a held output-valid strobe, with back-pressure, once every `gp_decim` samples after the line is full. It sits between the sample source and the shift register / downstream polyphase arithmetic.

## Interface
Parameters:
- `gp_nr_stages`, 4: depth of the controlled shift register; legal range ≥1.
- `gp_decim`, 4: decimation ratio R (samples per output); legal range ≥2.
- `c_ph_width` (local), `$clog2(gp_decim)`: phase width.
- `c_cnt_width` (local), `$clog2(gp_nr_stages+1)`: fill-count width; must represent `gp_nr_stages` itself.

Ports:
- `i_clk`, in, 1: rising-edge clock, the only clock.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_ena`, in, 1: synchronous active-high global enable; low freezes all state.
- `i_clear`, in, 1: synchronous flush pulse; restarts fill and phase.
- `i_valid`, in, 1: input sample present.
- `o_ready`, out, 1: block accepts a sample this cycle.
- `o_sr_ena`, out, 1: enable to the shift register; high exactly on accept cycles.
- `o_phase`, out, `c_ph_width`: commutator phase of the next sample to be accepted.
- `o_fill_done`, out, 1: the shift register holds `gp_nr_stages` valid samples; sticky.
- `o_out_valid`, out, 1: the shift register output/tap set forms a valid decimated output.
- `i_out_ready`, in, 1: downstream consumes output when high with `o_out_valid`.

## Operation
- Accept = `i_valid & o_ready`.
- `o_ready` = `i_ena & !i_rst & !i_clear & !o_out_valid` (combinational). No sample is accepted while an output is pending.
- `o_sr_ena` = accept (combinational). The shift register captures the sample on the same edge.
- Fill counter `r_cnt`:
  - Increments on accept.
  - Saturates at `gp_nr_stages`.
  - `o_fill_done` = (`r_cnt == gp_nr_stages`), registered. Stays high until reset or clear.
- Phase `o_phase`:
  - Increments on accept.
  - Wraps from `gp_decim-1` to 0.
  - Unaffected by fill state.
- Output event: accept with `o_phase == gp_decim-1` and (`o_fill_done` or `r_cnt == gp_nr_stages-1`).
  - On the next edge, `o_out_valid` is set.
  - Events before the line is primed are discarded silently; the phase still advances.
- `o_out_valid` clears on the edge where `i_out_ready` = 1. It holds indefinitely otherwise.
- State summary:
  - FILL: `o_fill_done` = 0.
  - RUN: `o_fill_done` = 1, `o_out_valid` = 0.
  - HOLD: `o_out_valid` = 1, `o_ready` = 0.
  - FILL→RUN/HOLD on the `gp_nr_stages`-th accept.
  - RUN→HOLD on an output event.
  - HOLD→RUN on `i_out_ready`.
  - Any→FILL on `i_clear` or `i_rst`.
- Priority: `i_rst` > `i_clear` > `i_ena` low (freeze) > normal operation.
- `i_clear`:
  - Next edge: `r_cnt` = 0, `o_phase` = 0, `o_fill_done` = 0, `o_out_valid` = 0 (a pending output is dropped).
  - `o_sr_ena` = 0 in the clear cycle.
  - The shift register contents are not flushed; they are overwritten during refill.
- `i_ena` low:
  - `o_ready` = 0, `o_sr_ena` = 0.
  - Counters, phase and `o_out_valid` hold.
  - `i_out_ready` is ignored.

## Timing
- Reset values, in the cycle after `i_rst` is sampled high: `o_out_valid` = 0, `o_fill_done` = 0, `o_phase` = 0, `r_cnt` = 0.
- `o_ready` and `o_sr_ena` read 0 while `i_rst` is high.
- `o_sr_ena` has zero-cycle latency from accept.
- `o_out_valid` rises 1 cycle after the qualifying accept, coincident with the new sample appearing at the shift register output.
- Throughput with `i_out_ready` tied high: R accepts, then a 1-cycle bubble (HOLD), repeating.
- `i_clear` asserted in the same cycle as `i_valid`: the sample is not accepted.
- `i_out_ready` and an output event cannot coincide, because accept requires `o_out_valid` = 0.
- `gp_nr_stages` > `gp_decim`: the first output occurs at the first phase wrap at or after the fill completes.
  - Example: N=6, R=4 gives the first output after accept #8.

## Test plan
- N=4, R=4, reset, `i_valid` = 1 continuously, `i_out_ready` = 1:
  - `o_sr_ena` high in cycles 0–3; `o_phase` shows 0,1,2,3,0.
  - `o_fill_done` and `o_out_valid` are high in cycle 4, with `o_ready` = 0.
  - Accepts resume in cycle 5; the next `o_out_valid` is in cycle 9.
- N=6, R=4, continuous input:
  - Wrap at accept #4 gives no output.
  - `o_fill_done` rises after accept #6.
  - First `o_out_valid` after accept #8; the next after accept #12 (+1 bubble cycle each).
- Back-pressure: hold `i_out_ready` = 0 for 5 cycles while HOLD.
  - `o_out_valid` stays 1 and `o_ready` stays 0 with zero `o_sr_ena` pulses.
  - `i_out_ready` = 1 clears HOLD; the accept proceeds in the following cycle.
- Clear mid-run after 2 accepts in RUN with `o_phase` = 2:
  - Pulse `i_clear` with `i_valid` = 1; no accept that cycle.
  - Next cycle `o_phase` = 0 and `o_fill_done` = 0.
  - N fresh accepts are required before the next output.
- Freeze: drop `i_ena` for 3 cycles during FILL (`r_cnt` = 2) and during HOLD.
  - All outputs hold; `o_sr_ena` = 0; `i_out_ready` is ignored.
  - Operation resumes unchanged.
- Reset mid-HOLD: assert `i_rst` for 1 cycle. Next cycle `o_out_valid` = 0, `o_fill_done` = 0, `o_phase` = 0; `o_ready` = 1 when `i_ena` = 1.
